// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared mode and state encodings for the immediate-extension arbiter
package imm_ext_pkg;
  localparam logic [1:0] MODE_SEXT   = 2'b00;
  localparam logic [1:0] MODE_ZEXT   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/imm_ext_arbiter_sign_extender.sv
// Sign_Extender: widens a 16-bit immediate to 32 bits by replicating its sign bit
module Sign_Extender (
  input  logic [15:0] imm,
  output logic [31:0] ext
);
  assign ext = {{16{imm[15]}}, imm};
endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin arbiter feeding one shared immediate extender with a one-entry result hold
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int BRANCH_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_imm,
  input  logic [3:0]  req_mode,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready
);
  state_t      state, state_nx;
  logic        last_grant;
  logic        can_accept;
  logic        win;
  logic [15:0] imm_sel;
  logic [1:0]  mode_sel;
  logic [31:0] sext;
  logic [31:0] result;
  Sign_Extender u_sext (
    .imm(imm_sel),
    .ext(sext)
  );
  // grant selection, extension mux and next state; req_ready is forced low during reset
  always_comb begin
    can_accept = rst_n && (state == ST_IDLE || rsp_ready);
    win        = &req_valid ? ~last_grant : req_valid[1];
    req_ready  = (can_accept && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    imm_sel    = win ? req_imm[31:16] : req_imm[15:0];
    mode_sel   = win ? req_mode[3:2] : req_mode[1:0];
    result     = mode_sel == MODE_SEXT  ? sext :
                 mode_sel == MODE_ZEXT  ? {16'h0000, imm_sel} :
                 mode_sel == MODE_UPPER ? {imm_sel, 16'h0000} :
                                          sext << BRANCH_SHIFT;
    state_nx   = |req_ready ? ST_HOLD :
                 (state == ST_HOLD && rsp_ready) ? ST_IDLE : state;
  end
  // state, arbitration history and the held result; the async reset drops any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state <= state_nx;
      if (|req_ready) begin
        last_grant <= win;
        rsp_id     <= win;
        rsp_data   <= result;
      end
    end
  end
  assign rsp_valid = state == ST_HOLD;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed and randomized checks against a behavioural model
module tb_imm_ext_arbiter;
  localparam int BS = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [31:0] req_imm = '0;
  logic [3:0]  req_mode = '0;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  logic        m_busy = 1'b0;
  int          m_last = 1;
  logic        m_id = 1'b0;
  logic [31:0] m_data = '0;
  logic [1:0]  last_rr = '0;
  imm_ext_arbiter #(.BRANCH_SHIFT(BS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_imm(req_imm),
    .req_mode(req_mode),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic logic [31:0] ext(logic [15:0] i, logic [1:0] m);
    int s;
    s = int'($signed(i));
    case (m)
      2'd0: return 32'(s);
      2'd1: return 32'(int'(i));
      2'd2: return 32'(int'(i) * 65536);
      default: return 32'(s * (2 ** BS));
    endcase
  endfunction
  function automatic int winner();
    if (req_valid == 2'b11) return 1 - m_last;
    return req_valid[1] ? 1 : 0;
  endfunction
  function automatic logic [1:0] exp_rr();
    if (!rst_n || (m_busy && !rsp_ready) || req_valid == 2'b00) return 2'b00;
    return winner() == 1 ? 2'b10 : 2'b01;
  endfunction
  // reference model: one held result, round-robin on ties, async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_last <= 1;
      m_id   <= 1'b0;
      m_data <= '0;
    end else if (!m_busy || rsp_ready) begin
      if (req_valid != 2'b00) begin
        m_busy <= 1'b1;
        m_last <= winner();
        m_id   <= winner() == 1;
        m_data <= winner() == 1 ? ext(req_imm[31:16], req_mode[3:2]) : ext(req_imm[15:0], req_mode[1:0]);
      end else m_busy <= 1'b0;
    end
  end
  // every-cycle comparison of DUT against the model, away from the active edge
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(exp_rr()));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_busy));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_data", rsp_data, m_data);
    last_rr = req_ready;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [1:0] v, logic [15:0] i1, logic [1:0] m1, logic [15:0] i0, logic [1:0] m0, logic r);
    req_valid = v;
    req_imm   = {i1, i0};
    req_mode  = {m1, m0};
    rsp_ready = r;
  endtask
  logic [31:0] held;
  logic        pend [2];
  logic [15:0] pimm [2];
  logic [1:0]  pmode [2];
  initial begin
    #1;
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    drive(2'b00, 16'h0, 2'd0, 16'h0, 2'd0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    drive(2'b01, 16'h5555, 2'd1, 16'hF000, 2'd0, 1'b1);
    #1;
    chk("sext_grant", 32'(req_ready), 32'h1);
    tick();
    chk("sext_valid", 32'(rsp_valid), 32'h1);
    chk("sext_id", 32'(rsp_id), 32'h0);
    chk("sext_data", rsp_data, 32'hFFFFF000);
    drive(2'b01, 16'h0, 2'd0, 16'h8310, 2'd1, 1'b1);
    #1;
    chk("zext_grant", 32'(req_ready), 32'h1);
    tick();
    chk("zext_data", rsp_data, 32'h00008310);
    drive(2'b01, 16'h0, 2'd0, 16'h9999, 2'd2, 1'b1);
    tick();
    chk("upper_data", rsp_data, 32'h99990000);
    drive(2'b01, 16'h0, 2'd0, 16'h8000, 2'd3, 1'b1);
    tick();
    chk("branch_data", rsp_data, 32'hFFFE0000);
    drive(2'b00, 16'h1111, 2'd2, 16'h2222, 2'd2, 1'b1);
    tick();
    chk("idle_valid", 32'(rsp_valid), 32'h0);
    chk("idle_data_kept", rsp_data, 32'hFFFE0000);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(2'b11, 16'hC000, 2'd3, 16'h0010, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), k % 2 == 0 ? 32'h1 : 32'h2);
      tick();
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
      chk("rr_data", rsp_data, k % 2 == 0 ? 32'h00000010 : 32'hFFFF0000);
    end
    rsp_ready = 1'b0;
    held = rsp_data;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_grant", 32'(req_ready), 32'h0);
      tick();
      chk("stall_data", rsp_data, held);
      chk("stall_valid", 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("resume_grant", 32'(req_ready), 32'h1);
    tick();
    chk("resume_id", 32'(rsp_id), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'h0);
    chk("async_rst_data", rsp_data, 32'h0);
    chk("async_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_id", 32'(rsp_id), 32'h0);
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (last_rr[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          pimm[i]  = 16'($urandom);
          pmode[i] = 2'($urandom);
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_async_rst", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
      end
      drive({pend[1], pend[0]},
            pend[1] ? pimm[1] : 16'($urandom), pend[1] ? pmode[1] : 2'($urandom),
            pend[0] ? pimm[0] : 16'($urandom), pend[0] ? pmode[0] : 2'($urandom),
            $urandom_range(0, 3) != 0);
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have parameter BRANCH_SHIFT, default 2, left-shift amount applied in mode 11.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 2; bit 0 is ALU-immediate requester, bit 1 is branch-offset requester.
REQ-005 SHALL have port req_imm, input, 32; {imm1[15:0], imm0[15:0]}.
REQ-006 SHALL have port req_mode, input, 4; {mode1[1:0], mode0[1:0]}.
REQ-007 SHALL have port req_ready, output, 2; one-hot grant, request accepted this cycle.
REQ-008 SHALL have port rsp_valid, output, 1; result held.
REQ-009 SHALL have port rsp_id, output, 1; requester index of held result.
REQ-010 SHALL have port rsp_data, output, 32; extended immediate.
REQ-011 SHALL have port rsp_ready, input, 1; consumer accepts result.

Function
REQ-012 SHALL implement FSM states IDLE and HOLD.
REQ-013 SHALL define "can_accept" as state==IDLE, or state==HOLD with rsp_ready=1.
REQ-014 SHALL assert at most one req_ready bit, only when can_accept and that requester's req_valid=1.
REQ-015 SHALL drive req_ready combinationally from req_valid, state, rsp_ready and last_grant.
REQ-016 SHALL arbitrate round-robin: one valid wins; both valid -> index != last_grant wins.
REQ-017 SHALL update last_grant to the winner on every accepted request.
REQ-018 SHALL, on accept, register rsp_data, rsp_id and rsp_valid=1 at the next edge (latency 1 cycle), next state HOLD.
REQ-019 SHALL in HOLD keep rsp_data/rsp_id stable until rsp_ready=1.
REQ-020 SHALL in HOLD with rsp_ready=1 and no req_valid go IDLE, rsp_valid=0 next cycle.
REQ-021 SHALL in HOLD with rsp_ready=1 and req_valid!=0 accept same cycle, stay HOLD with new result (throughput 1/cycle).
REQ-022 SHALL compute mode 00: sign-extend imm to 32 bits.
REQ-023 SHALL compute mode 01: zero-extend imm to 32 bits.
REQ-024 SHALL compute mode 10: {imm, 16'h0000}.
REQ-025 SHALL compute mode 11: sign-extended imm shifted left BRANCH_SHIFT, truncated to 32 bits.
REQ-026 SHALL ignore req_imm/req_mode of a non-granted requester; a losing requester holds its request until granted.
REQ-027 SHALL leave rsp_data unchanged in IDLE.

Reset
REQ-028 SHALL on rst_n=0 asynchronously force state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, last_grant=1.
REQ-029 SHALL deassert req_ready while rst_n=0.
REQ-030 SHALL on reset during HOLD drop the held result without a rsp_ready handshake.
REQ-031 SHALL accept a request in the first clock edge after rst_n rises, requester 0 winning a tie.

Structure
REQ-032 SHALL take mode encodings (MODE_SEXT, MODE_ZEXT, MODE_UPPER, MODE_BRANCH) and state encoding from shared package imm_ext_pkg.
REQ-033 SHALL instantiate the existing Sign_Extender module once as the single shared extender, fed by the granted requester's imm.
REQ-034 SHALL contain no other sub-module; muxing, shift and FSM are local.

Verification
REQ-035 SHALL test: req0 valid, mode 00, imm 0xF000 -> req_ready=01, next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFFFFF000.
REQ-036 SHALL test: mode 01 imm 0x8310 -> 0x00008310; mode 10 imm 0x9999 -> 0x99990000; mode 11 imm 0x8000 -> 0xFFFE0000.
REQ-037 SHALL test: both valid from reset, rsp_ready=1 -> grants 0,1,0,1 in consecutive cycles, one result per cycle.
REQ-038 SHALL test: rsp_ready=0 for 3 cycles in HOLD -> rsp_data stable, req_ready=00; rsp_ready=1 -> next request accepted same cycle.
REQ-039 SHALL test: rst_n low mid-HOLD -> rsp_valid=0 immediately (no clock edge); after release, requester 0 wins a tie.
